fifo_queue: RTL and testbench

- Synchronous first-in-first-out buffer. It is the queue-ordered counterpart of the team's stack block and uses the same wEn/dIn/full and rEn/dOut/empty handshake.
- It is a circular buffer with separate read and write pointers. Each pointer carries an extra wrap bit so full and empty can be told apart.
- Used wherever producer/consumer traffic must be retired in arrival order.
- It adds an occupancy count, an almost-full threshold and sticky overflow/underflow error flags.

---
 rtl/fifo_queue_if.sv | 27 ++
 rtl/fifo_queue.sv | 68 ++++++
 tb/tb_fifo_queue.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo_queue_if.sv
// Handshake bundle for fifo_queue: write side (wEn/dIn/full), read side
// (rEn/dOut/empty) and the occupancy/error status outputs.
interface fifo_queue_if #(
  parameter int BITWIDTH = 5,
  parameter int DEPTH    = 4
);
  logic                wEn;
  logic [BITWIDTH-1:0] dIn;
  logic                rEn;
  logic [BITWIDTH-1:0] dOut;
  logic                full;
  logic                empty;
  logic                almostFull;
  logic [DEPTH:0]      count;
  logic                overflow;
  logic                underflow;

  modport master (
    output wEn, dIn, rEn,
    input  dOut, full, empty, almostFull, count, overflow, underflow
  );

  modport slave (
    input  wEn, dIn, rEn,
    output dOut, full, empty, almostFull, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_queue.sv
// Circular-buffer FIFO with first-word fall-through output, occupancy count,
// almost-full threshold and sticky overflow/underflow flags.
module fifo_queue #(
  parameter int BITWIDTH    = 5,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 14
) (
  input  logic        clk,
  input  logic        rst,
  fifo_queue_if.slave q
);

  localparam int             ENTRIES   = 1 << DEPTH;
  localparam logic [DEPTH:0] AFULL_CNT = AFULL_LEVEL[DEPTH:0];

  logic [BITWIDTH-1:0] mem [0:ENTRIES-1];
  logic [DEPTH:0]      wPtr, rPtr;
  logic [DEPTH:0]      wPtr_nxt, rPtr_nxt;
  logic                overflow_r, underflow_r;
  logic                overflow_nxt, underflow_nxt;
  logic                full_c, empty_c;
  logic                wAcc, rAcc;
  logic [DEPTH:0]      count_c;

  // The extra wrap bit separates full (same slot, different lap) from empty.
  always_comb begin
    empty_c = (wPtr == rPtr);
    full_c  = (wPtr[DEPTH-1:0] == rPtr[DEPTH-1:0]) && (wPtr[DEPTH] != rPtr[DEPTH]);
    count_c = wPtr - rPtr;
  end

  // A write into a full queue is still legal when the head is popped this cycle.
  always_comb begin
    wAcc          = q.wEn & (~full_c | q.rEn);
    rAcc          = q.rEn & ~empty_c;
    wPtr_nxt      = wPtr;
    rPtr_nxt      = rPtr;
    overflow_nxt  = overflow_r | (q.wEn & full_c & ~q.rEn);
    underflow_nxt = underflow_r | (q.rEn & empty_c);
    if (wAcc) wPtr_nxt = wPtr + 1'b1;
    if (rAcc) rPtr_nxt = rPtr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wPtr        <= '0;
      rPtr        <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else begin
      if (wAcc) mem[wPtr[DEPTH-1:0]] <= q.dIn;
      wPtr        <= wPtr_nxt;
      rPtr        <= rPtr_nxt;
      overflow_r  <= overflow_nxt;
      underflow_r <= underflow_nxt;
    end
  end

  assign q.dOut       = rst ? '0 : mem[rPtr[DEPTH-1:0]];
  assign q.full       = full_c;
  assign q.empty      = empty_c;
  assign q.count      = count_c;
  assign q.almostFull = (count_c >= AFULL_CNT);
  assign q.overflow   = overflow_r;
  assign q.underflow  = underflow_r;

endmodule

// File: tb/tb_fifo_queue.sv
// Bench for fifo_queue: directed and random traffic checked against a
// queue-based model of the FIFO rules.
module tb_fifo_queue;

  localparam int BITWIDTH    = 5;
  localparam int DEPTH       = 4;
  localparam int AFULL_LEVEL = 14;
  localparam int ENTRIES     = 1 << DEPTH;

  logic clk = 1'b0;
  logic rst;

  fifo_queue_if #(.BITWIDTH(BITWIDTH), .DEPTH(DEPTH)) qif ();

  fifo_queue #(
    .BITWIDTH   (BITWIDTH),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(AFULL_LEVEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q  (qif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int mq[$];
  bit m_ovf;
  bit m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(qif.count), mq.size());
    chk({tag, ".empty"}, 32'(qif.empty), 32'(mq.size() == 0));
    chk({tag, ".full"}, 32'(qif.full), 32'(mq.size() == ENTRIES));
    chk({tag, ".afull"}, 32'(qif.almostFull), 32'(mq.size() >= AFULL_LEVEL));
    chk({tag, ".ovf"}, 32'(qif.overflow), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(qif.underflow), 32'(m_udf));
    if (mq.size() > 0) chk({tag, ".dout"}, 32'(qif.dOut), mq[0]);
  endtask

  // One clock of traffic; the model applies the accept rules to its pre-edge state.
  task automatic step(input string tag, input bit w, input int d, input bit r);
    bit was_full, was_empty;
    qif.wEn = w;
    qif.dIn = BITWIDTH'(d);
    qif.rEn = r;
    #1;
    if (r && mq.size() > 0) chk({tag, ".pop"}, 32'(qif.dOut), mq[0]);
    was_full  = (mq.size() == ENTRIES);
    was_empty = (mq.size() == 0);
    @(posedge clk);
    #1;
    if (r && !was_empty) void'(mq.pop_front());
    if (w && (!was_full || r)) mq.push_back(d);
    if (w && was_full && !r) m_ovf = 1'b1;
    if (r && was_empty) m_udf = 1'b1;
    qif.wEn = 1'b0;
    qif.rEn = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input bit w);
    rst     = 1'b1;
    qif.wEn = w;
    qif.rEn = 1'b0;
    qif.dIn = 5'd9;
    #1;
    chk({tag, ".dout_in_rst"}, 32'(qif.dOut), 0);
    @(posedge clk);
    #1;
    chk({tag, ".dout_in_rst2"}, 32'(qif.dOut), 0);
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    rst     = 1'b0;
    qif.wEn = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst     = 1'b1;
    qif.wEn = 1'b0;
    qif.rEn = 1'b0;
    qif.dIn = '0;
    @(negedge clk);

    // Reset with a write pending; the write must be discarded.
    do_reset("rst0", 1'b1);

    // Write 1,2,3 then drain.
    step("w1", 1'b1, 1, 1'b0);
    chk("w1.count_direct", 32'(qif.count), 1);
    chk("w1.dout_direct", 32'(qif.dOut), 1);
    step("w2", 1'b1, 2, 1'b0);
    step("w3", 1'b1, 3, 1'b0);
    chk("w3.count_direct", 32'(qif.count), 3);
    for (int i = 0; i < 3; i++) step("drain3", 1'b0, 0, 1'b1);

    // Fill to full, drop a write, then read back in order.
    for (int i = 0; i < ENTRIES; i++) step("fill", 1'b1, i, 1'b0);
    chk("fill.full_direct", 32'(qif.full), 1);
    step("ovf", 1'b1, 31, 1'b0);
    chk("ovf.flag_direct", 32'(qif.overflow), 1);
    chk("ovf.count_direct", 32'(qif.count), 16);
    for (int i = 0; i < ENTRIES; i++) step("drain16", 1'b0, 0, 1'b1);
    chk("drain16.empty_direct", 32'(qif.empty), 1);

    // Simultaneous read/write while full.
    for (int i = 0; i < ENTRIES; i++) step("fill2", 1'b1, i, 1'b0);
    step("full_rw", 1'b1, 20, 1'b1);
    chk("full_rw.full_direct", 32'(qif.full), 1);
    for (int i = 0; i < ENTRIES - 1; i++) step("drain15", 1'b0, 0, 1'b1);
    chk("drain15.last_direct", 32'(qif.dOut), 20);
    step("drain_last", 1'b0, 0, 1'b1);

    // Simultaneous read/write while empty.
    do_reset("rst1", 1'b0);
    step("empty_rw", 1'b1, 7, 1'b1);
    chk("empty_rw.udf_direct", 32'(qif.underflow), 1);
    chk("empty_rw.dout_direct", 32'(qif.dOut), 7);

    // Interleaved random traffic across pointer wraps.
    for (int i = 0; i < 40; i++)
      step("inter", 1'(i % 2 == 0), int'($urandom_range(0, 31)), 1'(i % 2 == 1));
    for (int i = 0; i < 300; i++) begin
      int bias;
      bias = (i / 50) % 2;
      step("rand",
           1'($urandom_range(0, 3) >= (bias ? 2 : 0) ? 1 : 0),
           int'($urandom_range(0, 31)),
           1'($urandom_range(0, 3) >= (bias ? 0 : 2) ? 1 : 0));
    end

    // Reset mid-stream with a write asserted.
    step("pre_rst", 1'b1, 5, 1'b0);
    do_reset("rst2", 1'b1);
    chk("rst2.count_direct", 32'(qif.count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
